gcd_dispatch: RTL

//  Upstream feeder and result holder for the gcd core. Buffers (a,b) operand pairs in a FIFO and

---
 rtl/gcd_dispatch.sv | 117 +++++++++++
 1 files changed

// File: rtl/gcd_dispatch.sv
// Operand FIFO and issue/response sequencer in front of the gcd core.
// Zero operands are answered locally (a|b) without involving the core.
module gcd_dispatch #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_a_i,
  input  logic [WIDTH-1:0]           in_b_i,
  output logic                       core_valid_o,
  output logic [WIDTH-1:0]           core_a_o,
  output logic [WIDTH-1:0]           core_b_o,
  input  logic                       core_ready_i,
  input  logic                       core_valid_i,
  input  logic [WIDTH-1:0]           core_gcd_i,
  output logic                       res_valid_o,
  output logic [WIDTH-1:0]           res_gcd_o,
  input  logic                       res_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] core_a_q, core_b_q, res_gcd_q;
  logic [WIDTH-1:0] head_a, head_b;
  logic             push, pop, fifo_empty, head_zero;

  assign fifo_empty = (count_q == '0);
  assign in_ready_o = (count_q != CW'(DEPTH));
  assign push       = in_valid_i && in_ready_o;
  assign head_a     = mem_a_q[rd_ptr_q];
  assign head_b     = mem_b_q[rd_ptr_q];
  assign head_zero  = (head_a == '0) || (head_b == '0);
  assign pop        = (state_q == IDLE) && !fifo_empty && (head_zero || core_ready_i);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a_i;
      mem_b_q[wr_ptr_q] <= in_b_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // The IDLE branch conditions mirror 'pop' so the FIFO and FSM advance together.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      core_a_q  <= '0;
      core_b_q  <= '0;
      res_gcd_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_zero) begin
              res_gcd_q <= head_a | head_b;
              state_q   <= RESP;
            end else if (core_ready_i) begin
              core_a_q <= head_a;
              core_b_q <= head_b;
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (core_valid_i) begin
            res_gcd_q <= core_gcd_i;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (res_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_valid_o = (state_q == ISSUE);
  assign core_a_o     = core_a_q;
  assign core_b_o     = core_b_q;
  assign res_valid_o  = (state_q == RESP);
  assign res_gcd_o    = res_gcd_q;
  assign fifo_count_o = count_q;

endmodule
